// File: rtl/intra_pred_seq_pkg.sv
// Shared encoder defines: sample bit depth, intra mode codes, sequencer states
// and the per-mode step counts used by the intra prediction sequencer.
package intra_pred_seq_pkg;

    localparam int unsigned BIT_DEPTH = 8;

    typedef enum logic [3:0] {
        MODE_I16_V  = 4'b0000,
        MODE_I16_H  = 4'b0001,
        MODE_I16_DC = 4'b0010,
        MODE_HOLD   = 4'b0111,
        MODE_CH_DC  = 4'b1000,
        MODE_CH_H   = 4'b1001,
        MODE_CH_V   = 4'b1010,
        MODE_IDLE   = 4'b1111
    } mode_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_I16_V,
        ST_I16_H,
        ST_I16_DC,
        ST_CH_H,
        ST_CH_V,
        ST_CH_DC,
        ST_DONE
    } state_t;

    localparam int unsigned STEPS_I16   = 16;
    localparam int unsigned STEPS_CH_HV = 8;
    localparam int unsigned STEPS_CH_DC = 4;

    function automatic logic is_luma(state_t s);
        return (s == ST_I16_V) || (s == ST_I16_H) || (s == ST_I16_DC);
    endfunction

    function automatic logic is_chroma(state_t s);
        return (s == ST_CH_H) || (s == ST_CH_V) || (s == ST_CH_DC);
    endfunction

    function automatic logic [3:0] last_idx(state_t s);
        logic [3:0] idx;
        idx = '0;
        case (s)
            ST_I16_V, ST_I16_H, ST_I16_DC: idx = 4'(STEPS_I16 - 1);
            ST_CH_H, ST_CH_V:              idx = 4'(STEPS_CH_HV - 1);
            ST_CH_DC:                      idx = 4'(STEPS_CH_DC - 1);
            default:                       idx = '0;
        endcase
        return idx;
    endfunction

    // Successor of a state in the fixed mode order; modes whose neighbour is
    // unavailable are skipped outright so they cost no cycles.
    function automatic state_t next_mode(state_t s, logic avail_t, logic avail_l);
        state_t n;
        n = ST_IDLE;
        case (s)
            ST_START:  n = avail_t ? ST_I16_V : (avail_l ? ST_I16_H : ST_I16_DC);
            ST_I16_V:  n = avail_l ? ST_I16_H : ST_I16_DC;
            ST_I16_H:  n = ST_I16_DC;
            ST_I16_DC: n = avail_l ? ST_CH_H : (avail_t ? ST_CH_V : ST_CH_DC);
            ST_CH_H:   n = avail_t ? ST_CH_V : ST_CH_DC;
            ST_CH_V:   n = ST_CH_DC;
            ST_CH_DC:  n = ST_DONE;
            default:   n = ST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/intra_pred_seq.sv
// Intra prediction sequencer: walks the luma 16x16 and chroma modes for one
// macroblock, one step per accepted cycle, skipping modes without neighbours.
module intra_pred_seq
    import intra_pred_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mb_start,
    input  logic       mb_avail_t,
    input  logic       mb_avail_l,
    input  logic       pred_ready,
    output logic       pred_start,
    output logic       pred_done,
    output logic [3:0] curr_mode,
    output logic [3:0] blk16x16_num,
    output logic [2:0] blk_uv_num,
    output logic       pred_valid,
    output logic       busy
);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       avail_t, avail_l;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            avail_t <= 1'b0;
            avail_l <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == ST_IDLE && mb_start) begin
                avail_t <= mb_avail_t;
                avail_l <= mb_avail_l;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                if (mb_start) state_nx = ST_START;
            end
            ST_START: begin
                state_nx = next_mode(ST_START, avail_t, avail_l);
                cnt_nx   = '0;
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
            default: begin
                if (pred_ready) begin
                    if (cnt == last_idx(state)) begin
                        state_nx = next_mode(state, avail_t, avail_l);
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 4'd1;
                    end
                end
            end
        endcase
    end

    // Directional modes show HOLD while stalled so a held step is not summed twice.
    always_comb begin
        curr_mode    = MODE_IDLE;
        pred_valid   = 1'b0;
        blk16x16_num = '0;
        blk_uv_num   = '0;
        pred_start   = (state == ST_START);
        pred_done    = (state == ST_DONE);
        busy         = (state != ST_IDLE);
        case (state)
            ST_I16_V:  curr_mode = pred_ready ? MODE_I16_V : MODE_HOLD;
            ST_I16_H:  curr_mode = pred_ready ? MODE_I16_H : MODE_HOLD;
            ST_I16_DC: curr_mode = MODE_I16_DC;
            ST_CH_H:   curr_mode = pred_ready ? MODE_CH_H : MODE_HOLD;
            ST_CH_V:   curr_mode = pred_ready ? MODE_CH_V : MODE_HOLD;
            ST_CH_DC:  curr_mode = MODE_CH_DC;
            default:   curr_mode = MODE_IDLE;
        endcase
        if (is_luma(state)) begin
            blk16x16_num = cnt;
            pred_valid   = pred_ready;
        end
        if (is_chroma(state)) begin
            blk_uv_num = cnt[2:0];
            pred_valid = pred_ready;
        end
    end

endmodule

// File: tb/tb_intra_pred_seq.sv
// Directed bench for intra_pred_seq: expected steps are queued when a
// macroblock is launched and popped as the sequencer presents them.
module tb_intra_pred_seq;
    import intra_pred_seq_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       mb_start;
    logic       mb_avail_t;
    logic       mb_avail_l;
    logic       pred_ready;
    logic       pred_start;
    logic       pred_done;
    logic [3:0] curr_mode;
    logic [3:0] blk16x16_num;
    logic [2:0] blk_uv_num;
    logic       pred_valid;
    logic       busy;

    intra_pred_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mb_start     (mb_start),
        .mb_avail_t   (mb_avail_t),
        .mb_avail_l   (mb_avail_l),
        .pred_ready   (pred_ready),
        .pred_start   (pred_start),
        .pred_done    (pred_done),
        .curr_mode    (curr_mode),
        .blk16x16_num (blk16x16_num),
        .blk_uv_num   (blk_uv_num),
        .pred_valid   (pred_valid),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        mode_t mode;
        int    b16;
        int    uv;
    } step_t;

    step_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    function automatic void push_mode(mode_t m, int n, bit luma);
        step_t s;
        for (int i = 0; i < n; i++) begin
            s.mode = m;
            s.b16  = luma ? i : 0;
            s.uv   = luma ? 0 : i;
            q.push_back(s);
        end
    endfunction

    function automatic void build(logic t, logic l);
        q.delete();
        if (t) push_mode(MODE_I16_V, 16, 1'b1);
        if (l) push_mode(MODE_I16_H, 16, 1'b1);
        push_mode(MODE_I16_DC, 16, 1'b1);
        if (l) push_mode(MODE_CH_H, 8, 1'b0);
        if (t) push_mode(MODE_CH_V, 8, 1'b0);
        push_mode(MODE_CH_DC, 4, 1'b0);
    endfunction

    // Called just after a rising edge with the DUT idle; returns the same way.
    task automatic run_mb(input logic t, input logic l, input int stall_pos,
                          input int stall_len, input int rnd_pct,
                          input bit restart_h7, input bit start_in_done);
        int    exp_len;
        int    c;
        int    popped;
        int    stall_left;
        int    stalls;
        bit    done;
        logic  rdy;
        logic  in_mode;
        mode_t hold_mode;

        build(t, l);
        exp_len    = 2 + 16 * (int'(t) + int'(l) + 1) + 8 * (int'(t) + int'(l)) + 4;
        popped     = 0;
        stalls     = 0;
        stall_left = stall_len;
        done       = 1'b0;

        mb_avail_t = t;
        mb_avail_l = l;
        mb_start   = 1'b1;
        pred_ready = 1'b1;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_mode", curr_mode, MODE_IDLE);
        @(posedge clk); #2;
        mb_start   = 1'b0;
        mb_avail_t = 1'b0;
        mb_avail_l = 1'b0;

        c = 1;
        while (!done && c <= 300) begin
            in_mode = (c >= 2) && (q.size() > 0);
            rdy = 1'b1;
            if (in_mode && popped == stall_pos && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else if (in_mode && rnd_pct > 0 && $urandom_range(99) < rnd_pct) begin
                rdy = 1'b0;
            end
            pred_ready = rdy;
            mb_start = (restart_h7 && q.size() > 0 && q[0].mode == MODE_I16_H && q[0].b16 == 7)
                    || (start_in_done && c == exp_len);
            #1;
            chk("busy", busy, 1);
            chk("pred_start", pred_start, (c == 1));
            chk("pred_valid", pred_valid, (in_mode && rdy));
            if (in_mode) begin
                hold_mode = (q[0].mode == MODE_I16_DC || q[0].mode == MODE_CH_DC) ? q[0].mode : MODE_HOLD;
                chk(rdy ? "step_mode" : "stall_mode", curr_mode, rdy ? q[0].mode : hold_mode);
                chk("blk16x16_num", blk16x16_num, q[0].b16);
                chk("blk_uv_num", blk_uv_num, q[0].uv);
                if (rdy) begin
                    void'(q.pop_front());
                    popped++;
                end else begin
                    stalls++;
                end
            end
            if (pred_done) begin
                done = 1'b1;
                chk("done_cycle", c, exp_len + stalls);
                chk("done_queue_empty", q.size(), 0);
                chk("done_mode", curr_mode, MODE_IDLE);
            end
            @(posedge clk); #2;
            mb_start = 1'b0;
            c++;
        end
        chk("done_seen", done, 1);
        pred_ready = 1'b1;
        #1;
        chk("after_busy", busy, 0);
        chk("after_done", pred_done, 0);
        chk("after_mode", curr_mode, MODE_IDLE);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mode"}, curr_mode, MODE_IDLE);
        chk({tag, "_start"}, pred_start, 0);
        chk({tag, "_done"}, pred_done, 0);
        chk({tag, "_valid"}, pred_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_b16"}, blk16x16_num, 0);
        chk({tag, "_uv"}, blk_uv_num, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst_n      = 1'b0;
        mb_start   = 1'b0;
        mb_avail_t = 1'b0;
        mb_avail_l = 1'b0;
        pred_ready = 1'b1;
        #3;
        chk_reset_vals("por");
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        chk_reset_vals("released");

        run_mb(1'b1, 1'b1, -1, 0, 0, 1'b0, 1'b0);
        run_mb(1'b0, 1'b0, -1, 0, 0, 1'b0, 1'b0);
        run_mb(1'b1, 1'b0, 5, 3, 0, 1'b0, 1'b0);
        run_mb(1'b0, 1'b1, -1, 0, 0, 1'b1, 1'b1);
        run_mb(1'b1, 1'b1, 40, 2, 0, 1'b0, 1'b0);
        run_mb(1'b1, 1'b1, 73, 3, 0, 1'b0, 1'b0);
        run_mb(1'b1, 1'b1, -1, 0, 30, 1'b0, 1'b0);

        // Abort at CH_V step 3 with an asynchronous reset between clock edges.
        mb_avail_t = 1'b1;
        mb_avail_l = 1'b1;
        mb_start   = 1'b1;
        pred_ready = 1'b1;
        @(posedge clk); #2;
        mb_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            #1;
            if (curr_mode == MODE_CH_V && blk_uv_num == 3'd3) found = 1'b1;
            else begin
                @(posedge clk); #2;
            end
        end
        chk("reach_chv3", found, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("post_rst_done", pred_done, 0);
            chk("post_rst_busy", busy, 0);
            @(posedge clk); #2;
        end
        run_mb(1'b1, 1'b1, -1, 0, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
